// File: rtl/movegen_pos_loader_if.sv
// Host-side bundle of the position loader: square writes, clear/start
// commands, status flags and the stream that feeds the first square.
interface movegen_pos_loader_if #(
  parameter int NUM_SQUARES = 64,
  parameter int DATA_W      = 4
);
  localparam int IDX_W = $clog2(NUM_SQUARES);

  logic              wr_valid;
  logic              wr_ready;
  logic [IDX_W-1:0]  wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              clear;
  logic              start;
  logic              busy;
  logic              done;
  logic              out_pos_valid;
  logic [DATA_W-1:0] out_pos_data;

  // The position source (host or search controller) drives requests.
  modport master (
    output wr_valid, wr_addr, wr_data, clear, start,
    input  wr_ready, busy, done, out_pos_valid, out_pos_data
  );

  // The loader accepts requests and produces status and the square stream.
  modport slave (
    input  wr_valid, wr_addr, wr_data, clear, start,
    output wr_ready, busy, done, out_pos_valid, out_pos_data
  );
endinterface

// File: rtl/movegen_pos_loader.sv
// Position loader at the head of the movegen_square shift chain.
// Holds one board position written square by square, then on start streams
// it into the chain highest square first so that square k ends up holding
// buffer entry k once all beats have passed.
module movegen_pos_loader #(
  parameter int NUM_SQUARES = 64,
  parameter int DATA_W      = 4
) (
  input logic                clk,
  input logic                rst,
  movegen_pos_loader_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_SQUARES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] buf_q [NUM_SQUARES];
  logic [DATA_W-1:0] buf_d [NUM_SQUARES];
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;

  // Next-state logic: buffer edits only happen in IDLE, and start wins over
  // a same-cycle write/clear so the shifted position is exactly what was
  // buffered before the command.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    valid_d = 1'b0;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          idx_d   = IDX_W'(NUM_SQUARES - 1);
        end else begin
          if (bus.clear) begin
            for (int i = 0; i < NUM_SQUARES; i++) begin
              buf_d[i] = '0;
            end
          end
          if (bus.wr_valid) begin
            buf_d[bus.wr_addr] = bus.wr_data;
          end
        end
      end
      SHIFT: begin
        valid_d = 1'b1;
        data_d  = buf_q[idx_q];
        idx_d   = idx_q - IDX_W'(1);
        if (idx_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, buffer and registered stream outputs; reset aborts any stream
  // immediately and empties the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      buf_q   <= '{default: '0};
      valid_q <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign bus.wr_ready      = (state_q == IDLE);
  assign bus.busy          = (state_q == SHIFT);
  assign bus.done          = done_q;
  assign bus.out_pos_valid = valid_q;
  assign bus.out_pos_data  = data_q;
endmodule

// File: tb/tb_movegen_pos_loader.sv
// Scoreboard bench for movegen_pos_loader: a reference buffer is updated as
// writes are driven, the expected beat sequence is queued at each start, and
// beats are popped and compared as they appear; a 64-deep chain model checks
// where each square lands.
module tb_movegen_pos_loader;
  localparam int NSQ = 64;
  localparam int DW  = 4;

  logic clk;
  logic rst;

  movegen_pos_loader_if #(.NUM_SQUARES(NSQ), .DATA_W(DW)) bus ();

  movegen_pos_loader #(.NUM_SQUARES(NSQ), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] model [NSQ];
  logic [DW-1:0] chain [NSQ];
  logic [DW-1:0] expQ [$];
  logic          expectIdle;

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one request cycle; the reference buffer follows only when the
  // loader should be idle and no start is present.
  task automatic applyStimulus(input logic v, input int addr, input logic [DW-1:0] d,
                               input logic clr, input logic st);
    @(posedge clk);
    #1;
    bus.wr_valid = v;
    bus.wr_addr  = addr[5:0];
    bus.wr_data  = d;
    bus.clear    = clr;
    bus.start    = st;
    checkOutput("wrReadyAtDrive", {31'd0, bus.wr_ready}, {31'd0, expectIdle});
    if (expectIdle && !st) begin
      if (clr) begin
        for (int i = 0; i < NSQ; i++) model[i] = '0;
      end
      if (v) model[addr] = d;
    end
    @(posedge clk);
    #1;
    bus.wr_valid = 1'b0;
    bus.clear    = 1'b0;
    bus.start    = 1'b0;
  endtask

  // Issue start (optionally with a same-cycle write/clear that must be
  // dropped), then follow the stream cycle by cycle. injectAt drives a
  // write+clear of sq10 mid-stream; rstAt asserts reset mid-stream.
  task automatic runShift(input logic wv, input int wa, input logic [DW-1:0] wd,
                          input logic clr, input int injectAt, input int rstAt);
    logic [DW-1:0] exp;
    for (int k = NSQ - 1; k >= 0; k--) expQ.push_back(model[k]);
    applyStimulus(wv, wa, wd, clr, 1'b1);
    expectIdle = 1'b0;
    @(negedge clk);
    checkOutput("validBeforeFirstBeat", {31'd0, bus.out_pos_valid}, 32'd0);
    checkOutput("busyAfterStart", {31'd0, bus.busy}, 32'd1);
    for (int i = 1; i <= NSQ; i++) begin
      @(negedge clk);
      bus.wr_valid = 1'b0;
      bus.clear    = 1'b0;
      checkOutput($sformatf("beatValid%0d", i - 1), {31'd0, bus.out_pos_valid}, 32'd1);
      if (expQ.size() == 0) begin
        checkOutput("queueUnderflow", 32'd1, 32'd0);
      end else begin
        exp = expQ.pop_front();
        checkOutput($sformatf("beatData%0d", i - 1), {28'd0, bus.out_pos_data}, {28'd0, exp});
      end
      if (bus.out_pos_valid) begin
        for (int k = NSQ - 1; k > 0; k--) chain[k] = chain[k-1];
        chain[0] = bus.out_pos_data;
      end
      checkOutput("doneDuringStream", {31'd0, bus.done}, 32'd0);
      if (i == injectAt) begin
        checkOutput("wrReadyWhileBusy", {31'd0, bus.wr_ready}, 32'd0);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 6'd10;
        bus.wr_data  = 4'h7;
        bus.clear    = 1'b1;
      end
      if (i == rstAt) begin
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abortValid", {31'd0, bus.out_pos_valid}, 32'd0);
        checkOutput("abortData", {28'd0, bus.out_pos_data}, 32'd0);
        checkOutput("abortBusy", {31'd0, bus.busy}, 32'd0);
        checkOutput("abortDone", {31'd0, bus.done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abortNoDone", {31'd0, bus.done}, 32'd0);
        checkOutput("abortWrReady", {31'd0, bus.wr_ready}, 32'd1);
        for (int k = 0; k < NSQ; k++) model[k] = '0;
        expQ.delete();
        expectIdle = 1'b1;
        return;
      end
    end
    @(negedge clk);
    checkOutput("donePulse", {31'd0, bus.done}, 32'd1);
    checkOutput("validAfterStream", {31'd0, bus.out_pos_valid}, 32'd0);
    checkOutput("busyAfterStream", {31'd0, bus.busy}, 32'd0);
    checkOutput("wrReadyAfterStream", {31'd0, bus.wr_ready}, 32'd1);
    checkOutput("queueDrained", expQ.size(), 32'd0);
    @(negedge clk);
    checkOutput("doneOneCycle", {31'd0, bus.done}, 32'd0);
    expectIdle = 1'b1;
  endtask

  // Test sequence.
  initial begin
    rst          = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.clear    = 1'b0;
    bus.start    = 1'b0;
    expectIdle   = 1'b1;
    for (int k = 0; k < NSQ; k++) begin
      model[k] = '0;
      chain[k] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstWrReady", {31'd0, bus.wr_ready}, 32'd1);
    checkOutput("rstBusy", {31'd0, bus.busy}, 32'd0);
    checkOutput("rstDone", {31'd0, bus.done}, 32'd0);
    checkOutput("rstValid", {31'd0, bus.out_pos_valid}, 32'd0);
    checkOutput("rstData", {28'd0, bus.out_pos_data}, 32'd0);
    rst = 1'b0;

    $display("[TB] empty position");
    runShift(1'b0, 0, 4'h0, 1'b0, -1, -1);

    $display("[TB] three written squares");
    applyStimulus(1'b1, 0, 4'h1, 1'b0, 1'b0);
    applyStimulus(1'b1, 7, 4'h9, 1'b0, 1'b0);
    applyStimulus(1'b1, 63, 4'hE, 1'b0, 1'b0);
    runShift(1'b0, 0, 4'h0, 1'b0, -1, -1);
    checkOutput("chainSq63", {28'd0, chain[63]}, 32'hE);
    checkOutput("chainSq7", {28'd0, chain[7]}, 32'h9);
    checkOutput("chainSq0", {28'd0, chain[0]}, 32'h1);
    checkOutput("chainSq1", {28'd0, chain[1]}, 32'h0);

    $display("[TB] buffer preserved across shifts");
    applyStimulus(1'b1, 5, 4'h3, 1'b0, 1'b0);
    runShift(1'b0, 0, 4'h0, 1'b0, -1, -1);
    runShift(1'b0, 0, 4'h0, 1'b0, -1, -1);
    checkOutput("chainSq5", {28'd0, chain[5]}, 32'h3);

    $display("[TB] write and clear ignored while busy");
    runShift(1'b0, 0, 4'h0, 1'b0, 30, -1);
    runShift(1'b0, 0, 4'h0, 1'b0, -1, -1);
    checkOutput("chainSq10Kept", {28'd0, chain[10]}, 32'h0);
    checkOutput("chainSq5Kept", {28'd0, chain[5]}, 32'h3);

    $display("[TB] start drops a same-cycle write");
    runShift(1'b1, 20, 4'hA, 1'b0, -1, -1);
    checkOutput("chainSq20Dropped", {28'd0, chain[20]}, 32'h0);

    $display("[TB] same-cycle clear and write");
    applyStimulus(1'b1, 3, 4'h5, 1'b1, 1'b0);
    runShift(1'b0, 0, 4'h0, 1'b0, -1, -1);
    checkOutput("chainSq3", {28'd0, chain[3]}, 32'h5);
    checkOutput("chainSq63Cleared", {28'd0, chain[63]}, 32'h0);
    checkOutput("chainSq5Cleared", {28'd0, chain[5]}, 32'h0);

    $display("[TB] reset mid-stream");
    runShift(1'b0, 0, 4'h0, 1'b0, -1, 20);
    runShift(1'b0, 0, 4'h0, 1'b0, -1, -1);
    checkOutput("chainSq3AfterRst", {28'd0, chain[3]}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
